tmds_chan_decoder: RTL and testbench

Per-channel TMDS receive decoder for the HDMI/DVI sink path: the receive-side counterpart of the per-channel encoders in `hdmi_encoder_top`. It takes one 10-bit TMDS symbol per pixel clock from a 1:10 deserializer and recovers `dout[7:0]`, the control bits and video data-enable. A word-alignment state machine issues `bitslip` pulses to the deserializer until control-token runs confirm symbol lock. Three instances, one per channel, feed a downstream channel-deskew and timing-measurement stage.

---
 rtl/tmds_chan_decoder.sv | 191 +++++++++++++++++++
 tb/tb_tmds_chan_decoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_chan_decoder.sv
// tmds_chan_decoder
// Per-channel DVI/TMDS receive decoder with word alignment. One 10-bit symbol
// arrives per pixel clock from a 1:10 deserializer. The block decodes it into
// a pixel byte, or into the two control bits when the symbol is a control
// token. A small state machine watches for runs of control tokens. When no
// run is seen within a search window, it requests a one-bit word-boundary
// shift from the deserializer.
//
// Ports
//   pclk      in   pixel clock (only clock)
//   rstin     in   synchronous active-high reset
//   sdata     in   [9:0] received symbol, bit 0 first on the wire
//   dout      out  [7:0] decoded pixel byte (0 while not aligned)
//   c0, c1    out  control bits from the last control token
//   vde       out  video data enable (data symbol while aligned)
//   bitslip   out  one-cycle word-boundary shift request
//   aligned   out  symbol lock
//   slip_cnt  out  [3:0] slips issued, counting 0..9 and wrapping

module tmds_chan_decoder #(
  parameter int CTRL_RUN   = 64,
  parameter int SEARCH_LEN = 4096,
  parameter int SLIP_WAIT  = 16
) (
  input  logic       pclk,
  input  logic       rstin,
  input  logic [9:0] sdata,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       vde,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_cnt
);

  localparam int         WIN_W    = $clog2(SEARCH_LEN);
  localparam logic [7:0] RUN_MAX  = 8'(CTRL_RUN);
  localparam logic [7:0] WAIT_END = 8'(SLIP_WAIT - 1);
  localparam logic [WIN_W-1:0] WIN_END = WIN_W'(SEARCH_LEN - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  state_e           state_q;
  logic [7:0]       run_q;
  logic [7:0]       run_d;
  logic [WIN_W-1:0] win_q;
  logic [7:0]       wait_q;

  logic       is_ctrl;
  logic [1:0] ctrl_bits;
  logic [7:0] data_byte;
  logic       counting;
  logic       hit;
  logic       win_exp;
  logic       lock_next;

  // Undo the TMDS transition-minimising stage: bit 9 marks an inverted byte,
  // and bit 8 selects XOR (1) or XNOR (0) chaining.
  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  function automatic logic [7:0] sat_run(input logic [7:0] r);
    return (r >= RUN_MAX) ? RUN_MAX : r + 8'd1;
  endfunction

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_bits = 2'b00;
    unique case (sdata)
      TOK_00:  ctrl_bits = 2'b00;
      TOK_01:  ctrl_bits = 2'b01;
      TOK_10:  ctrl_bits = 2'b10;
      TOK_11:  ctrl_bits = 2'b11;
      default: is_ctrl   = 1'b0;
    endcase

    data_byte = tmds_decode(sdata);

    // Runs are only qualified while searching or locked. During SLIP and
    // WAIT the counter is parked at zero so SEARCH restarts cleanly.
    counting = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
    run_d    = (counting && is_ctrl) ? sat_run(run_q) : 8'd0;
    hit      = counting && is_ctrl && (run_q == RUN_MAX - 8'd1);
    win_exp  = (win_q == WIN_END);

    // Value aligned takes at this edge. The output stage gates with it so
    // that the symbol completing a run already appears as aligned.
    lock_next = 1'b0;
    if (state_q == ST_SEARCH) begin
      lock_next = hit;
    end else if (state_q == ST_LOCKED) begin
      lock_next = hit || !win_exp;
    end
  end

  always_ff @(posedge pclk) begin
    if (rstin) begin
      state_q  <= ST_SEARCH;
      run_q    <= 8'd0;
      win_q    <= '0;
      wait_q   <= 8'd0;
      bitslip  <= 1'b0;
      aligned  <= 1'b0;
      slip_cnt <= 4'd0;
      dout     <= 8'd0;
      c0       <= 1'b0;
      c1       <= 1'b0;
      vde      <= 1'b0;
    end else begin
      run_q   <= run_d;
      bitslip <= 1'b0;
      aligned <= lock_next;

      unique case (state_q)
        ST_SEARCH: begin
          // A hit in the expiry cycle takes priority over slipping.
          if (hit) begin
            state_q <= ST_LOCKED;
            win_q   <= '0;
          end else if (win_exp) begin
            state_q  <= ST_SLIP;
            win_q    <= '0;
            bitslip  <= 1'b1;
            slip_cnt <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
          end else begin
            win_q <= win_q + WIN_W'(1);
          end
        end
        ST_SLIP: begin
          state_q <= ST_WAIT;
          wait_q  <= 8'd0;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_END) begin
            state_q <= ST_SEARCH;
            win_q   <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          // Losing lock drops back to searching without slipping: the
          // boundary was good, the source may simply have paused blanking.
          if (hit) begin
            win_q <= '0;
          end else if (win_exp) begin
            state_q <= ST_SEARCH;
            win_q   <= '0;
          end else begin
            win_q <= win_q + WIN_W'(1);
          end
        end
        default: state_q <= ST_SEARCH;
      endcase

      // Output register stage
      if (is_ctrl) begin
        c0  <= ctrl_bits[0];
        c1  <= ctrl_bits[1];
        vde <= 1'b0;
        if (!lock_next) begin
          dout <= 8'd0;
        end
      end else begin
        vde  <= lock_next;
        dout <= lock_next ? data_byte : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_chan_decoder.sv
`timescale 1ns/1ps
module tb_tmds_chan_decoder;

  localparam int CTRL_RUN    = 64;
  localparam int SEARCH_LEN  = 4096;
  localparam int SLIP_WAIT   = 16;
  localparam int SLIP_PERIOD = SEARCH_LEN + SLIP_WAIT + 1;
  localparam int LINE_LEN    = 2200;
  localparam int LINE_ACT    = 1920;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  typedef struct packed {
    logic       aligned;
    logic       vde;
    logic       c1;
    logic       c0;
    logic [7:0] dout;
  } exp_t;

  logic       pclk  = 1'b0;
  logic       rstin = 1'b1;
  logic [9:0] sdata = 10'd0;
  logic [7:0] dout;
  logic       c0;
  logic       c1;
  logic       vde;
  logic       bitslip;
  logic       aligned;
  logic [3:0] slip_cnt;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   off   = 0;
  int   sidx  = 0;
  exp_t sb[$];

  tmds_chan_decoder #(
    .CTRL_RUN  (CTRL_RUN),
    .SEARCH_LEN(SEARCH_LEN),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .pclk    (pclk),
    .rstin   (rstin),
    .sdata   (sdata),
    .dout    (dout),
    .c0      (c0),
    .c1      (c1),
    .vde     (vde),
    .bitslip (bitslip),
    .aligned (aligned),
    .slip_cnt(slip_cnt)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic a, input logic v, input logic h1,
                                  input logic h0, input logic [7:0] d);
    exp_t e;
    e.aligned = a;
    e.vde     = v;
    e.c1      = h1;
    e.c0      = h0;
    e.dout    = d;
    return e;
  endfunction

  // Pseudo-random data symbol that is never a control token.
  function automatic logic [9:0] data_sym(input int i);
    logic [9:0] w;
    w = 10'((i * 389 + 77) ^ (i >>> 2));
    if (w == TOK00 || w == TOK01 || w == TOK10 || w == TOK11) w = w ^ 10'd1;
    return w;
  endfunction

  // Simplified video line: active data followed by a blanking run.
  function automatic logic [9:0] line_sym(input int i);
    return ((i % LINE_LEN) < LINE_ACT) ? data_sym(i) : TOK00;
  endfunction

  // Word seen by the decoder when the deserializer boundary is r bits late.
  function automatic logic [9:0] wire_word(input int i, input int r);
    logic [19:0] two;
    two = {line_sym(i + 1), line_sym(i)};
    return two[r +: 10];
  endfunction

  task automatic test_reset();
    rstin = 1'b1;
    sdata = TOK11;
    repeat (3) tick();
    total++;
    if (dout !== 8'h00) begin
      bad++; $display("FAIL reset_dout: got %h want 00", dout);
    end
    total++;
    if ({c1, c0, vde} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got c1c0vde=%b want 000", {c1, c0, vde});
    end
    total++;
    if ({bitslip, aligned, slip_cnt} !== 6'd0) begin
      bad++; $display("FAIL reset_align: got bitslip=%b aligned=%b slip_cnt=%0d want 0/0/0",
                      bitslip, aligned, slip_cnt);
    end
    rstin = 1'b0;
  endtask

  task automatic test_alignment();
    exp_t e;
    exp_t got;
    int   slips = 0;
    for (int i = 0; i < 100 + CTRL_RUN; i++) begin
      if (i < 100) begin
        sdata = data_sym(i);
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
      end else begin
        sdata = TOK00;
        sb.push_back(mk_exp(i == 100 + CTRL_RUN - 1, 1'b0, 1'b0, 1'b0, 8'h00));
      end
      tick();
      if (bitslip !== 1'b0) slips++;
      e   = sb.pop_front();
      got = {aligned, vde, c1, c0, dout};
      total++;
      if (got !== e) begin
        bad++; $display("FAIL align[%0d]: got %h want %h", i, got, e);
      end
    end
    total++;
    if (slips !== 0) begin
      bad++; $display("FAIL align_noslip: got %0d pulses want 0", slips);
    end
  endtask

  task automatic test_decode();
    logic [9:0] syms[7];
    exp_t       exps[7];
    exp_t       e;
    exp_t       got;
    syms[0] = 10'b0100000000; exps[0] = mk_exp(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    syms[1] = TOK11;          exps[1] = mk_exp(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    syms[2] = 10'b1000000000; exps[2] = mk_exp(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    syms[3] = TOK01;          exps[3] = mk_exp(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    syms[4] = 10'b0000000000; exps[4] = mk_exp(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE);
    syms[5] = 10'b0100000001; exps[5] = mk_exp(1'b1, 1'b1, 1'b0, 1'b1, 8'h03);
    syms[6] = TOK10;          exps[6] = mk_exp(1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
    for (int i = 0; i < 7; i++) begin
      sdata = syms[i];
      sb.push_back(exps[i]);
      tick();
      e   = sb.pop_front();
      got = {aligned, vde, c1, c0, dout};
      total++;
      if (got !== e) begin
        bad++; $display("FAIL decode[%0d] sdata=%b: got %h want %h", i, syms[i], got, e);
      end
    end
  endtask

  task automatic test_run63();
    int locked = 0;
    rstin = 1'b1;
    sdata = TOK00;
    tick();
    rstin = 1'b0;
    for (int i = 0; i < 10 + (CTRL_RUN - 1) + 100; i++) begin
      sdata = (i >= 10 && i < 10 + CTRL_RUN - 1) ? TOK00 : data_sym(i);
      tick();
      if (aligned !== 1'b0) locked++;
    end
    total++;
    if (locked !== 0) begin
      bad++; $display("FAIL run63_nolock: aligned high for %0d cycles want 0", locked);
    end
  endtask

  task automatic test_misaligned();
    int r;
    int first;
    int spacing_bad = 0;
    int leak = 0;
    int slip_at[$];
    rstin = 1'b1;
    sdata = TOK00;
    tick();
    rstin = 1'b0;
    r    = cyc;
    off  = 3;
    sidx = 0;
    for (int n = 0; n < 40000 && aligned !== 1'b1; n++) begin
      sdata = wire_word(sidx, off);
      sidx++;
      tick();
      if (bitslip === 1'b1) begin
        slip_at.push_back(cyc);
        off = (off + 1) % 10;
      end
      if (aligned !== 1'b1 && (vde !== 1'b0 || dout !== 8'h00)) leak++;
    end
    total++;
    if (aligned !== 1'b1) begin
      bad++; $display("FAIL misalign_lock: got aligned=%b want 1 (timeout)", aligned);
    end
    total++;
    if (slip_at.size() !== 7) begin
      bad++; $display("FAIL misalign_slips: got %0d pulses want 7", slip_at.size());
    end
    total++;
    if (slip_cnt !== 4'd7) begin
      bad++; $display("FAIL misalign_slip_cnt: got %0d want 7", slip_cnt);
    end
    first = (slip_at.size() > 0) ? slip_at[0] : -1;
    total++;
    if (first !== r + SEARCH_LEN) begin
      bad++; $display("FAIL misalign_first: got cycle %0d want %0d", first, r + SEARCH_LEN);
    end
    for (int k = 1; k < slip_at.size(); k++) begin
      if (slip_at[k] - slip_at[k-1] != SLIP_PERIOD) spacing_bad++;
    end
    total++;
    if (spacing_bad !== 0) begin
      bad++; $display("FAIL misalign_spacing: got %0d bad gaps want 0", spacing_bad);
    end
    total++;
    if (leak !== 0) begin
      bad++; $display("FAIL misalign_gating: got %0d ungated cycles want 0", leak);
    end
  endtask

  task automatic test_lock_loss();
    int h;
    int f = -1;
    int prev;
    int s;
    int drops = 0;
    // Fresh run so the window start is known exactly.
    sdata = data_sym(1);
    tick();
    for (int i = 0; i < CTRL_RUN; i++) begin
      sdata = TOK00;
      tick();
    end
    h = cyc;
    total++;
    if (aligned !== 1'b1) begin
      bad++; $display("FAIL relock: got aligned=%b want 1", aligned);
    end
    // Run of TOK11 whose last token lands in the window expiry cycle.
    for (int i = 0; i < SEARCH_LEN; i++) begin
      sdata = (i >= SEARCH_LEN - CTRL_RUN) ? TOK11 : data_sym(i);
      tick();
      if (aligned !== 1'b1) drops++;
    end
    total++;
    if (drops !== 0) begin
      bad++; $display("FAIL expiry_hit_keeps_lock: got %0d unlocked cycles want 0", drops);
    end
    for (int n = 0; n < SEARCH_LEN + 100 && f < 0; n++) begin
      sdata = data_sym(n + 7);
      tick();
      if (aligned === 1'b0) f = cyc;
    end
    total++;
    if (f !== h + 2 * SEARCH_LEN) begin
      bad++; $display("FAIL lock_fall: got cycle %0d want %0d", f, h + 2 * SEARCH_LEN);
    end
    total++;
    if ({vde, dout} !== 9'd0) begin
      bad++; $display("FAIL unlock_gating: got vde=%b dout=%h want 0/00", vde, dout);
    end
    prev = f;
    for (int k = 0; k < 3; k++) begin
      s = -1;
      for (int n = 0; n < SLIP_PERIOD + 100 && s < 0; n++) begin
        sdata = data_sym(n + 3);
        tick();
        if (bitslip === 1'b1) s = cyc;
      end
      off = (off + 1) % 10;
      total++;
      if (s !== prev + ((k == 0) ? SEARCH_LEN : SLIP_PERIOD)) begin
        bad++; $display("FAIL slip_time[%0d]: got cycle %0d want %0d", k, s,
                        prev + ((k == 0) ? SEARCH_LEN : SLIP_PERIOD));
      end
      total++;
      if (slip_cnt !== 4'((8 + k) % 10)) begin
        bad++; $display("FAIL slip_cnt[%0d]: got %0d want %0d", k, slip_cnt, (8 + k) % 10);
      end
      prev  = s;
      sdata = data_sym(k);
      tick();
      total++;
      if (bitslip !== 1'b0) begin
        bad++; $display("FAIL bitslip_width[%0d]: got %b want 0", k, bitslip);
      end
    end
  endtask

  task automatic test_reset_wait();
    int s = -1;
    int pulses = 0;
    for (int n = 0; n < SLIP_PERIOD + 100 && s < 0; n++) begin
      sdata = data_sym(n + 11);
      tick();
      if (bitslip === 1'b1) s = cyc;
    end
    total++;
    if (slip_cnt !== 4'd1) begin
      bad++; $display("FAIL pre_reset_slip_cnt: got %0d want 1", slip_cnt);
    end
    repeat (5) begin
      sdata = data_sym(5);
      tick();
    end
    rstin = 1'b1;
    tick();
    rstin = 1'b0;
    total++;
    if ({dout, c1, c0, vde} !== 11'd0) begin
      bad++; $display("FAIL wait_reset_data: got dout=%h c1c0=%b vde=%b want 00/00/0",
                      dout, {c1, c0}, vde);
    end
    total++;
    if ({bitslip, aligned, slip_cnt} !== 6'd0) begin
      bad++; $display("FAIL wait_reset_ctrl: got bitslip=%b aligned=%b slip_cnt=%0d want 0/0/0",
                      bitslip, aligned, slip_cnt);
    end
    repeat (SLIP_WAIT + 30) begin
      sdata = data_sym(9);
      tick();
      if (bitslip !== 1'b0) pulses++;
    end
    total++;
    if (pulses !== 0 || slip_cnt !== 4'd0) begin
      bad++; $display("FAIL wait_reset_noslip: got %0d pulses slip_cnt=%0d want 0/0",
                      pulses, slip_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alignment();
    test_decode();
    test_run63();
    test_misaligned();
    test_lock_loss();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
